// File: rtl/cic_pkg.sv
// Shared CIC helpers: FSM state type, phase-counter sizing and register-growth arithmetic.
// Used by both the interpolator and the decimator gain checks.
package cic_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    BURST = 1'b1
  } cic_interp_state_t;

  localparam int unsigned CIC_FACTOR_DEFAULT = 313;
  localparam int unsigned CIC_PHASE_W        = $clog2(CIC_FACTOR_DEFAULT);

  function automatic int unsigned cic_phase_bits(input int unsigned factor);
    return $clog2(factor);
  endfunction

  // ceil(log2((factor*delay)^stages / factor)) = ceil(log2(factor^(stages-1) * delay^stages))
  function automatic int unsigned cic_growth_bits(input int unsigned factor,
                                                  input int unsigned delay,
                                                  input int unsigned stages);
    logic [127:0] gain;
    int unsigned  bits;
    gain = 128'd1;
    for (int unsigned k = 0; k < stages; k++) gain = gain * 128'(delay);
    for (int unsigned k = 1; k < stages; k++) gain = gain * 128'(factor);
    bits = 0;
    for (int unsigned b = 0; b < 128; b++) begin
      if ((128'd1 << b) < gain) bits = b + 1;
    end
    return bits;
  endfunction

endpackage

// File: rtl/cic_interp_comb.sv
// One CIC comb stage: output = input minus the input seen DELAY enabled samples ago.
// The delay line only advances when en_i is high (input-rate accept).
module cic_interp_comb #(
  parameter int WIDTH = 65,
  parameter int DELAY = 2
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    en_i,
  input  logic signed [WIDTH-1:0] data_i,
  output logic signed [WIDTH-1:0] data_o
);

  logic signed [WIDTH-1:0] line_q [DELAY];

  // Delay line shift register, cleared by synchronous reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int k = 0; k < DELAY; k++) line_q[k] <= {WIDTH{1'b0}};
    end else if (en_i) begin
      line_q[0] <= data_i;
      for (int k = 1; k < DELAY; k++) line_q[k] <= line_q[k-1];
    end
  end

  assign data_o = data_i - line_q[DELAY-1];

endmodule

// File: rtl/cic_interp.sv
// Complex Hogenauer CIC interpolator: input-rate comb chain, zero-stuffing, output-rate
// pipelined integrators, FACTOR output samples per accepted input with valid/ready on both sides.
module cic_interp
  import cic_pkg::*;
#(
  parameter int WIDTH  = 65,
  parameter int FACTOR = 313,
  parameter int DELAY  = 2,
  parameter int STAGES = 5
) (
  input  logic                    i_clock,
  input  logic                    i_reset,
  input  logic signed [WIDTH-1:0] i_inph_data,
  input  logic signed [WIDTH-1:0] i_quad_data,
  input  logic                    i_valid,
  output logic                    o_ready,
  output logic signed [WIDTH-1:0] o_inph_data,
  output logic signed [WIDTH-1:0] o_quad_data,
  output logic                    o_valid,
  input  logic                    i_ready
);

  localparam int PW = cic_phase_bits(FACTOR);
  localparam logic [PW-1:0] PHASE_LAST = PW'(FACTOR - 1);
  localparam logic [PW-1:0] PHASE_ZERO = {PW{1'b0}};
  localparam logic signed [WIDTH-1:0] DATA_ZERO = {WIDTH{1'b0}};

  cic_interp_state_t state_q, state_d;
  logic [PW-1:0]     phase_q, phase_d;
  logic              accept_s, fire_s, last_s;

  logic signed [WIDTH-1:0] comb_inph_q, comb_quad_q;
  logic signed [WIDTH-1:0] stuff_inph_s, stuff_quad_s;
  logic signed [WIDTH-1:0] integ_inph_q [STAGES];
  logic signed [WIDTH-1:0] integ_quad_q [STAGES];

  assign last_s   = (phase_q == PHASE_LAST);
  assign o_valid  = (state_q == BURST);
  // Combinational from i_ready so the last phase of a burst can hand over without a bubble
  assign o_ready  = (state_q == IDLE) || ((state_q == BURST) && last_s && i_ready);
  assign accept_s = i_valid && o_ready;
  assign fire_s   = o_valid && i_ready;

  // State and phase registers
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q <= IDLE;
      phase_q <= PHASE_ZERO;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
    end
  end

  // Next-state logic: phase advances per fire, last phase either re-accepts or returns to IDLE
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    case (state_q)
      IDLE: begin
        if (accept_s) begin
          state_d = BURST;
          phase_d = PHASE_ZERO;
        end else begin
          state_d = IDLE;
        end
      end
      BURST: begin
        if (fire_s && last_s) begin
          phase_d = PHASE_ZERO;
          state_d = accept_s ? BURST : IDLE;
        end else if (fire_s) begin
          phase_d = phase_q + PW'(1'b1);
        end else begin
          phase_d = phase_q;
        end
      end
      default: begin
        state_d = IDLE;
        phase_d = PHASE_ZERO;
      end
    endcase
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_comb
    logic signed [WIDTH-1:0] inph_in_s, quad_in_s, inph_out_s, quad_out_s;
    if (k == 0) begin : g_first
      assign inph_in_s = i_inph_data;
      assign quad_in_s = i_quad_data;
    end else begin : g_next
      assign inph_in_s = g_comb[k-1].inph_out_s;
      assign quad_in_s = g_comb[k-1].quad_out_s;
    end
    cic_interp_comb #(.WIDTH(WIDTH), .DELAY(DELAY)) u_inph (
      .clk_i (i_clock), .rst_i (i_reset), .en_i (accept_s),
      .data_i(inph_in_s), .data_o(inph_out_s)
    );
    cic_interp_comb #(.WIDTH(WIDTH), .DELAY(DELAY)) u_quad (
      .clk_i (i_clock), .rst_i (i_reset), .en_i (accept_s),
      .data_i(quad_in_s), .data_o(quad_out_s)
    );
  end

  // Comb output register, loaded once per accepted input
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      comb_inph_q <= DATA_ZERO;
      comb_quad_q <= DATA_ZERO;
    end else if (accept_s) begin
      comb_inph_q <= g_comb[STAGES-1].inph_out_s;
      comb_quad_q <= g_comb[STAGES-1].quad_out_s;
    end
  end

  // Zero-stuffing: the comb result enters the integrators only on phase 0
  always_comb begin
    if (phase_q == PHASE_ZERO) begin
      stuff_inph_s = comb_inph_q;
      stuff_quad_s = comb_quad_q;
    end else begin
      stuff_inph_s = DATA_ZERO;
      stuff_quad_s = DATA_ZERO;
    end
  end

  // Pipelined integrators; each stage adds the previous stage's registered value, frozen on stall
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      for (int k = 0; k < STAGES; k++) begin
        integ_inph_q[k] <= DATA_ZERO;
        integ_quad_q[k] <= DATA_ZERO;
      end
    end else if (fire_s) begin
      integ_inph_q[0] <= integ_inph_q[0] + stuff_inph_s;
      integ_quad_q[0] <= integ_quad_q[0] + stuff_quad_s;
      for (int k = 1; k < STAGES; k++) begin
        integ_inph_q[k] <= integ_inph_q[k] + integ_inph_q[k-1];
        integ_quad_q[k] <= integ_quad_q[k] + integ_quad_q[k-1];
      end
    end
  end

  assign o_inph_data = integ_inph_q[STAGES-1];
  assign o_quad_data = integ_quad_q[STAGES-1];

endmodule
